// File: rtl/frame_reader_pkg.sv
// Shared types and defaults for the frame reader: raster defaults, pixel type and
// the read-side FSM state encoding.
package frame_pkg;
    localparam int DEFAULT_H_RES      = 640;
    localparam int DEFAULT_V_RES      = 480;
    localparam int DEFAULT_DATA_WIDTH = 15;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rd_state_e;
endpackage

// File: rtl/frame_reader_if.sv
// Pixel stream interface from the frame reader to the display/output stage:
// valid/ready handshake with start-of-frame and end-of-line tags.
interface frame_reader_if import frame_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_sof;
    logic                  m_eol;

    modport master (output m_data, m_valid, m_sof, m_eol, input m_ready);
    modport slave  (input m_data, m_valid, m_sof, m_eol, output m_ready);
endinterface

// File: rtl/frame_reader_pixel_skid_fifo.sv
// Two-entry FIFO holding {pixel, sof, eol} words between the RAM read port and the
// output handshake; the head is presented straight from the storage registers.
module pixel_skid_fifo import frame_pkg::*; #(
    parameter int WIDTH = DEFAULT_DATA_WIDTH + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_occ
);
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_occ;
    logic       w_pop;

    assign w_pop = i_pop && (r_occ != 2'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [WIDTH-1:0] r_entry;
            always_ff @(posedge clk) begin
                if (i_push && (r_wr_ptr == 1'(gi)))
                    r_entry <= i_din;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({i_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head = r_rd_ptr ? g_entry[1].r_entry : g_entry[0].r_entry;
    assign o_occ  = r_occ;
endmodule

// File: rtl/frame_reader.sv
// Raster-order frame-buffer reader: sweeps RAM addresses, absorbs the 1-cycle read
// latency and emits a tagged pixel stream. Optional frame counter: FRAME_READER_FRAME_CNT_EN.
module frame_reader import frame_pkg::*; #(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int H_RES         = DEFAULT_H_RES,
    parameter int V_RES         = DEFAULT_V_RES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic                     READ_EN,
    input  logic [DATA_WIDTH-1:0]    RGB,
    frame_reader_if.master           m_if,
    output logic                     busy,
    output logic                     frame_done
`ifdef FRAME_READER_FRAME_CNT_EN
    ,
    output logic [15:0]              frame_count
`endif
);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(H_RES * V_RES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] X_LAST    = ADDRESS_WIDTH'(H_RES - 1);
    localparam int                       LW        = $clog2(V_RES + 1);
    localparam logic [LW-1:0]            LINE_LAST = LW'(V_RES - 1);

    rd_state_e               r_state;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] r_x;
    logic                    r_inflight;
    logic                    r_tag_sof;
    logic                    r_tag_eol;
    logic                    r_busy;
    logic                    r_done_seen;
    logic [LW-1:0]           r_out_line;

    logic [1:0]              w_occ;
    logic [DATA_WIDTH+1:0]   w_head;
    logic                    w_valid;
    logic                    w_pop;
    logic [2:0]              w_pending;
    logic                    w_issue;
    logic                    w_frame_done;

    pixel_skid_fifo #(.WIDTH(DATA_WIDTH + 2)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_inflight),
        .i_din  ({RGB, r_tag_sof, r_tag_eol}),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_occ  (w_occ)
    );

    // Credit check: buffered + in-flight words after this cycle's pop must leave a free slot.
    assign w_valid      = (w_occ != 2'd0);
    assign w_pop        = w_valid && m_if.m_ready;
    assign w_pending    = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = (r_state == RUN) && (w_pending < 3'd2);
    assign w_frame_done = w_pop && w_head[0] && (r_out_line == LINE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_x         <= '0;
            r_inflight  <= 1'b0;
            r_tag_sof   <= 1'b0;
            r_tag_eol   <= 1'b0;
            r_busy      <= 1'b0;
            r_done_seen <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag_sof <= (r_addr == '0);
                r_tag_eol <= (r_x == X_LAST);
            end
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= RUN;
                        r_addr  <= '0;
                        r_x     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        r_x <= (r_x == X_LAST) ? '0 : r_x + 1'b1;
                        if (r_addr == LAST_ADDR) begin
                            r_addr      <= '0;
                            r_done_seen <= 1'b0;
                            if (!enable)
                                r_state <= FLUSH;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (w_frame_done)
                        r_done_seen <= 1'b1;
                    // Leave as the last pixel is accepted so busy drops the following cycle.
                    if (!r_inflight && (w_pending == 3'd0) && (w_frame_done || r_done_seen)) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_done_seen <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line count of accepted pixels identifies the final pixel of the frame.
    always_ff @(posedge clk) begin
        if (rst)
            r_out_line <= '0;
        else if (w_pop && w_head[0])
            r_out_line <= (r_out_line == LINE_LAST) ? '0 : r_out_line + 1'b1;
    end

`ifdef FRAME_READER_FRAME_CNT_EN
    logic [15:0] r_frame_count;
    always_ff @(posedge clk) begin
        if (rst)
            r_frame_count <= 16'd0;
        else if (w_frame_done)
            r_frame_count <= r_frame_count + 16'd1;
    end
    assign frame_count = r_frame_count;
`endif

    assign rd_addr        = r_addr;
    assign READ_EN        = w_issue;
    assign busy           = r_busy;
    assign frame_done     = w_frame_done;
    assign m_if.m_valid   = w_valid;
    assign m_if.m_data    = w_head[DATA_WIDTH+1:2];
    assign m_if.m_sof     = w_valid && w_head[1];
    assign m_if.m_eol     = w_valid && w_head[0];
endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader with a 4x2 raster and a RAM model holding mem[i]=i.
module tb_frame_reader;
    import frame_pkg::*;

    localparam int AW = 20;
    localparam int DW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [AW-1:0] rd_addr;
    logic          READ_EN;
    logic [DW-1:0] RGB = '0;
    logic          busy;
    logic          frame_done;
`ifdef FRAME_READER_FRAME_CNT_EN
    logic [15:0]   frame_count;
`endif

    frame_reader_if #(.DATA_WIDTH(DW)) m_if ();

    frame_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .H_RES(4), .V_RES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rd_addr    (rd_addr),
        .READ_EN    (READ_EN),
        .RGB        (RGB),
        .m_if       (m_if),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef FRAME_READER_FRAME_CNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [8];
    always @(posedge clk) begin
        if (READ_EN)
            RGB <= mem[rd_addr[2:0]];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        m_if.m_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic          en;
        logic          rdy;
        logic          ren;
        logic [AW-1:0] addr;
        logic          vld;
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          fd;
        logic          bsy;
    } vec_t;

    function automatic vec_t v(int en, int rdy, int ren, int addr, int vld, int data,
                               int sof, int eol, int fd, int bsy);
        vec_t r;
        r.en = 1'(en); r.rdy = 1'(rdy); r.ren = 1'(ren); r.addr = AW'(addr);
        r.vld = 1'(vld); r.data = DW'(data); r.sof = 1'(sof); r.eol = 1'(eol);
        r.fd = 1'(fd); r.bsy = 1'(bsy);
        return r;
    endfunction

    vec_t tbl [20];

    int            issued;
    int            acc;
    int            nfd;
    int            expv;
    logic          prev_stall;
    logic          prev_fd;
    logic [DW+1:0] prev_word;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = DW'(i);
        m_if.m_ready = 1'b1;

        //            en rdy ren addr vld data sof eol fd busy
        tbl[0]  = v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = v(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[3]  = v(1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        tbl[4]  = v(1, 1, 1, 2, 1, 0, 1, 0, 0, 1);
        tbl[5]  = v(1, 1, 1, 3, 1, 1, 0, 0, 0, 1);
        tbl[6]  = v(1, 1, 1, 4, 1, 2, 0, 0, 0, 1);
        tbl[7]  = v(1, 1, 1, 5, 1, 3, 0, 1, 0, 1);
        tbl[8]  = v(1, 1, 1, 6, 1, 4, 0, 0, 0, 1);
        tbl[9]  = v(1, 1, 1, 7, 1, 5, 0, 0, 0, 1);
        tbl[10] = v(1, 1, 1, 0, 1, 6, 0, 0, 0, 1);
        tbl[11] = v(1, 1, 1, 1, 1, 7, 0, 1, 1, 1);
        tbl[12] = v(1, 1, 1, 2, 1, 0, 1, 0, 0, 1);
        tbl[13] = v(1, 1, 1, 3, 1, 1, 0, 0, 0, 1);
        tbl[14] = v(1, 1, 1, 4, 1, 2, 0, 0, 0, 1);
        tbl[15] = v(1, 1, 1, 5, 1, 3, 0, 1, 0, 1);
        tbl[16] = v(1, 1, 1, 6, 1, 4, 0, 0, 0, 1);
        tbl[17] = v(1, 1, 1, 7, 1, 5, 0, 0, 0, 1);
        tbl[18] = v(1, 1, 1, 0, 1, 6, 0, 0, 0, 1);
        tbl[19] = v(1, 1, 1, 1, 1, 7, 0, 1, 1, 1);

        // Back-to-back streaming with m_ready held high.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            enable = tbl[i].en;
            m_if.m_ready = tbl[i].rdy;
            #1;
            chk("tbl_read_en", READ_EN, tbl[i].ren);
            if (tbl[i].ren) chk("tbl_rd_addr", rd_addr, tbl[i].addr);
            chk("tbl_valid", m_if.m_valid, tbl[i].vld);
            if (tbl[i].vld) begin
                chk("tbl_data", m_if.m_data, tbl[i].data);
                chk("tbl_sof", m_if.m_sof, tbl[i].sof);
                chk("tbl_eol", m_if.m_eol, tbl[i].eol);
            end
            chk("tbl_frame_done", frame_done, tbl[i].fd);
            chk("tbl_busy", busy, tbl[i].bsy);
            $display("row %0d: ren=%0b addr=%0d valid=%0b data=%0d sof=%0b eol=%0b fd=%0b busy=%0b",
                     i, READ_EN, rd_addr, m_if.m_valid, m_if.m_data, m_if.m_sof, m_if.m_eol,
                     frame_done, busy);
        end

        // Random backpressure over two frames.
        do_reset();
        issued = 0; acc = 0; prev_stall = 1'b0; prev_word = '0;
        for (int c = 0; c < 400 && acc < 16; c++) begin
            @(negedge clk);
            enable = 1'b1;
            m_if.m_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                chk("stall_valid_held", m_if.m_valid, 1);
                chk("stall_word_held", {m_if.m_sof, m_if.m_eol, m_if.m_data}, prev_word);
            end
            if (READ_EN) issued++;
            if (m_if.m_valid && m_if.m_ready) begin
                expv = acc % 8;
                chk("rand_data", m_if.m_data, expv);
                chk("rand_sof", m_if.m_sof, expv == 0);
                chk("rand_eol", m_if.m_eol, (expv % 4) == 3);
                chk("rand_frame_done", frame_done, expv == 7);
                $display("accept %0d: data=%0d sof=%0b eol=%0b fd=%0b",
                         acc, m_if.m_data, m_if.m_sof, m_if.m_eol, frame_done);
                acc++;
            end else begin
                chk("rand_no_frame_done", frame_done, 0);
            end
            chk("rand_outstanding_le2", (issued - acc) <= 2, 1);
            prev_stall = m_if.m_valid && !m_if.m_ready;
            prev_word  = {m_if.m_sof, m_if.m_eol, m_if.m_data};
        end
        chk("rand_accepted_count", acc, 16);

        // Drop enable after pixel 2 of frame 0: frame still completes, then idle.
        do_reset();
        issued = 0; acc = 0; nfd = 0; prev_fd = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            enable = (acc < 3);
            m_if.m_ready = 1'b1;
            #1;
            if (prev_fd) chk("drop_busy_cleared", busy, 0);
            if (READ_EN) issued++;
            if (m_if.m_valid && m_if.m_ready) begin
                chk("drop_data", m_if.m_data, acc % 8);
                acc++;
            end
            if (frame_done) nfd++;
            prev_fd = frame_done;
        end
        $display("drop test: reads=%0d accepted=%0d frame_done=%0d busy=%0b", issued, acc, nfd, busy);
        chk("drop_reads", issued, 8);
        chk("drop_accepted", acc, 8);
        chk("drop_frame_done_count", nfd, 1);
        chk("drop_busy_final", busy, 0);
        chk("drop_state_idle", dut.r_state == IDLE, 1);

        // m_ready low from the start: exactly two reads, then resume at addr 2.
        do_reset();
        issued = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            enable = 1'b1;
            m_if.m_ready = 1'b0;
            #1;
            if (READ_EN) begin
                chk("hold_rd_addr", rd_addr, issued);
                issued++;
            end
        end
        chk("hold_read_count", issued, 2);
        chk("hold_head", {m_if.m_valid, m_if.m_sof, m_if.m_data}, {1'b1, 1'b1, 15'd0});
        @(negedge clk);
        m_if.m_ready = 1'b1;
        #1;
        $display("release: ren=%0b addr=%0d data=%0d", READ_EN, rd_addr, m_if.m_data);
        chk("release_read_en", READ_EN, 1);
        chk("release_rd_addr", rd_addr, 2);
        chk("release_data", m_if.m_data, 0);

        // Reset while two pixels are buffered and m_ready is low.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            enable = 1'b1;
            m_if.m_ready = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        m_if.m_ready = 1'b1;
        #1;
        chk("rst_valid", m_if.m_valid, 0);
        chk("rst_read_en", READ_EN, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("rst_no_frame_done", frame_done, 0);
        end
        @(negedge clk);
        enable = 1'b1;
        #1;
        chk("restart_idle_no_read", READ_EN, 0);
        @(negedge clk);
        #1;
        chk("restart_read_en", READ_EN, 1);
        chk("restart_rd_addr", rd_addr, 0);
        repeat (2) @(negedge clk);
        #1;
        $display("restart: valid=%0b sof=%0b data=%0d", m_if.m_valid, m_if.m_sof, m_if.m_data);
        chk("restart_valid", m_if.m_valid, 1);
        chk("restart_sof", m_if.m_sof, 1);
        chk("restart_data", m_if.m_data, 0);

`ifdef FRAME_READER_FRAME_CNT_EN
        // Three frames; counter visible the cycle after each frame_done.
        do_reset();
        #1;
        chk("fcnt_reset", frame_count, 0);
        nfd = 0; prev_fd = 1'b0;
        for (int c = 0; c < 60 && nfd < 3; c++) begin
            @(negedge clk);
            enable = 1'b1;
            m_if.m_ready = 1'b1;
            #1;
            if (prev_fd) chk("fcnt_after_done", frame_count, nfd);
            if (frame_done) begin
                chk("fcnt_before_incr", frame_count, nfd);
                nfd++;
            end
            prev_fd = frame_done;
        end
        @(negedge clk);
        #1;
        $display("frame_count=%0d after %0d frames", frame_count, nfd);
        chk("fcnt_final", frame_count, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Downstream consumer of the frame-buffer RAM.
- Sweeps read addresses 0..H_RES*V_RES-1 in raster order and drives the RAM read port (rd_addr, READ_EN).
- Absorbs the RAM's 1-cycle registered read latency and emits a valid/ready pixel stream with start-of-frame and end-of-line tags to the display/output stage.
- Full backpressure support; 1 pixel/cycle sustained when m_ready is held high.

Parameters:
- ADDRESS_WIDTH, 20, RAM address width; must satisfy H_RES*V_RES <= 2**ADDRESS_WIDTH.
- DATA_WIDTH, 15, pixel width (RGB555).
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  level; run frames while high.
- rd_addr  output  ADDRESS_WIDTH  RAM read address.
- READ_EN  output  1  RAM read strobe.
- RGB  input  DATA_WIDTH  RAM read data, valid the cycle after READ_EN.
- m_data  output  DATA_WIDTH  pixel.
- m_valid  output  1  pixel valid.
- m_ready  input  1  downstream accept.
- m_sof  output  1  qualifies m_data as pixel 0 of a frame.
- m_eol  output  1  qualifies m_data as the last pixel of a line.
- busy  output  1  high from frame start until the last pixel is accepted.
- frame_done  output  1  1-cycle pulse on acceptance of the final pixel of a frame.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: rd_addr=0, READ_EN=0, m_valid=0, m_sof=0, m_eol=0, busy=0, frame_done=0, state=IDLE. Buffer is flushed and the in-flight flag cleared.
- Reset mid-frame: the partial frame is discarded and no frame_done is produced.
- IDLE state:
  - Waits for enable=1.
  - On enable=1, go to RUN with addr=0, x=0, next_sof=1.
- RUN state:
  - Issue a read (READ_EN=1, rd_addr=addr) when occ + inflight - (m_valid & m_ready) < 2.
  - occ = output buffer occupancy (0..2); inflight = read issued last cycle.
  - Each issued read carries its sof/eol tags through a 1-cycle tag pipe alongside the RAM latency.
  - Tag rules: sof = (addr==0); eol = (x==H_RES-1).
  - On each issue: addr += 1; x wraps H_RES-1 -> 0.
  - On the issue of addr = H_RES*V_RES-1:
    - if enable=1, addr <- 0 and stay in RUN (back-to-back frames, no bubble);
    - else go to FLUSH.
  - Dropping enable mid-frame does not abort: the frame completes, then the block goes to FLUSH.
- FLUSH state: no reads issued. Go to IDLE once inflight=0, occ=0 and frame_done has fired.
- Data capture: when inflight=1, the buffer writes {RGB, tags} at the end of that cycle.
- Latency: enable sampled in IDLE at cycle N:
  - READ_EN=1 with rd_addr=0 at N+1;
  - m_valid=1 with m_sof=1 at N+3.
- Handshake:
  - m_data, m_sof and m_eol are held stable while m_valid=1 and m_ready=0.
  - The buffer never overflows; no pixel is dropped or duplicated.
  - Simultaneous buffer write and pop are allowed.
- busy:
  - Set on the IDLE->RUN transition.
  - Cleared the cycle after frame_done when the block returns to IDLE; stays high across back-to-back frames.
- frame_done: asserted in the cycle a pixel with address H_RES*V_RES-1 is accepted (m_valid & m_ready).
- Width rule: addr and x counters are ADDRESS_WIDTH bits wide; the terminal compare uses the constant H_RES*V_RES-1. There is no wrap beyond that value.

Optional Feature:
- Macro: FRAME_READER_FRAME_CNT_EN.
- When defined:
  - Adds output frame_count (16 bits), reset to 0.
  - Increments on every frame_done pulse and wraps 0xFFFF -> 0.
  - The new value is visible the cycle after frame_done.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package frame_pkg:
  - DEFAULT_H_RES and DEFAULT_V_RES localparams;
  - pixel_t (logic [DATA_WIDTH-1:0], default 15);
  - the rd_state_e enum {IDLE, RUN, FLUSH}.
- Sub-module pixel_skid_fifo:
  - 2-entry FIFO of {pixel, sof, eol};
  - exposes occ, push, pop and head;
  - no combinational path from m_ready to push.

Test Plan:
- H_RES=4, V_RES=2, m_ready=1, RAM preloaded mem[i]=i, enable held high:
  - READ_EN at N+1 and first pixel at N+3;
  - stream 0..7 then 0..7 with no gaps;
  - m_sof on pixels 0; m_eol on pixels 3 and 7;
  - frame_done after each 7; busy stays high.
- Same setup, random m_ready at 50%: the accepted sequence is exactly 0..7 in order, data is stable while stalled, and there is never more than 2 outstanding reads plus buffered pixels.
- enable dropped at pixel 2 of frame 0: all 8 pixels are still delivered, frame_done fires once, no further READ_EN, then busy=0 and state=IDLE.
- rst asserted while the buffer holds 2 pixels and m_ready=0: the next cycle has m_valid=0 and READ_EN=0, no frame_done, and a restart with enable begins again at addr 0 with m_sof.
- m_ready=0 from the start: READ_EN fires exactly twice (addr 0, 1) and then stalls; releasing m_ready resumes at addr 2.
- FRAME_READER_FRAME_CNT_EN defined, 3 frames run: frame_count reads 1, 2, 3, each one cycle after its frame_done.
